fc_mem_slave: RTL and testbench
===============================

# fc_mem_slave

Bus responder with on-chip word memory that answers the burst requests issued by the fully-connected unit's read and write controllers. It accepts read-address and write-address requests, serves read bursts tagged with the requester's id, and absorbs byte-strobed write bursts while signalling the last expected beat. It stands in for the external memory side of the FC datapath, for simulation and small-model on-chip storage.

## Interface
- `width`, 32: data bus width in bits; multiple of 8.
- `depth`, 1024: memory depth in words; power of two.
- `aw`, 28: byte address width.
- `clk` in 1: clock, all logic rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `awaddr` in aw: write burst start byte address.
- `awlen` in 4: write beats minus one.
- `awuser_id` in 4: write requester id.
- `awuser_ap` in 1: 1 = incrementing burst, 0 = fixed-address burst.
- `awvalid` in 1 / `awready` out 1: write address handshake.
- `wdata` in width, `wstrb` in width/8, `wvalid` in 1: write beat.
- `wready` out 1: responder accepts beat.
- `wuser_id` out 4: id of the write burst being absorbed.
- `wuser_last` out 1: current accepted beat is the final one.
- `araddr` in aw, `arlen` in 4, `aruser_id` in 4, `aruser_ap` in 1: read request, same meanings as the write side.
- `arvalid` in 1 / `arready` out 1: read address handshake.
- `rdata` out width, `rvalid` out 1, `rlast` out 1, `rid` out 4: read beat; no rready, the requester must take every beat.

## Operation
- Word index = `addr[lsb +: log2(depth)]`, `lsb = log2(width/8)`. Upper address bits are ignored, so indices wrap modulo `depth`. Low `lsb` bits are ignored.
- Burst length is `len+1` beats, range 1..16. With `ap=1`, the index increments per beat and wraps from `depth-1` to 0. With `ap=0`, every beat uses the start index.
- FSM states:
  - IDLE: accepts one request.
  - WR: absorbs the write burst.
  - RD_ISSUE: first SRAM read.
  - RD: streams read beats.
- Transitions:
  - IDLE→WR on `awvalid&awready`.
  - IDLE→RD_ISSUE on `arvalid&arready`.
  - RD_ISSUE→RD unconditionally.
  - WR→IDLE after the last beat is accepted.
  - RD→IDLE after the beat with `rlast`.
- Arbitration in IDLE:
  - `awready = idle & awvalid & ~(arvalid & pick_rd)`.
  - `arready = idle & arvalid & ~(awvalid & ~pick_rd)`.
  - `pick_rd` toggles to favour the other channel after every grant (round-robin). Reset value is 0, so write wins the first tie.
  - With a single requester, that requester is granted immediately.
- Request fields are latched on acceptance: base index, len, id, ap.
- WR:
  - `wready=1`, `wuser_id` = latched id.
  - On `wvalid`, each byte lane whose `wstrb` bit is set is written; other lanes keep their value.
  - A beat counter advances per accepted beat. `wuser_last` = (count == len), combinational while in WR.
  - No write response is generated.
- RD: one synchronous-read SRAM port, one beat per cycle. `rid` = latched id. `rlast` is asserted on beat `len`.
- A single shared memory port means only one burst is in flight at a time, and no request is accepted outside IDLE.

## Timing
- Reset values:
  - Outputs `awready`, `arready`, `wready`, `wuser_last`, `rvalid`, `rlast` = 0.
  - `wuser_id`, `rid`, `rdata` = 0.
  - State = IDLE, `pick_rd` = 0.
  - Memory array is not reset.
- Write: AW accepted in cycle T; `wready` is high from T+1. A beat presented with `wvalid` in cycle T+k is written at the end of T+k; the data is readable by a read accepted the following cycle. After the last beat in cycle L, the FSM is in IDLE in L+1 and a new request can be accepted in L+1.
- Read: AR accepted in cycle T; beat 0 is presented (`rvalid`=1) in T+2, then consecutive beats with no gaps. The `rlast` beat occurs in T+2+len. The FSM is in IDLE in T+3+len.
- Mid-burst `wvalid`=0: `wready` stays high, the counter holds, and the burst waits indefinitely.
- Reset asserted mid-burst: the burst is abandoned at that edge, already-written words persist, and there is no partial rvalid.
- Simultaneous `awvalid` and `arvalid` in IDLE: exactly one ready is asserted, per `pick_rd`.

## Test plan
- Single write/read: AW addr 0x10, len 0, id 3, wdata 0xDEADBEEF, strb 0xF. Then AR addr 0x10, len 0, id 5 → in T+2: rdata 0xDEADBEEF, rvalid=1, rlast=1, rid=5.
- Incrementing burst with wrap: AW addr (depth-2)*4, len 3, ap 1, data 1,2,3,4 → wuser_last only on beat 3; words at indices depth-2, depth-1, 0, 1 = 1,2,3,4. Read back the same burst → 1,2,3,4 with rlast on the 4th beat.
- Byte strobe: word holds 0xAABBCCDD, write 0x11223344 with strb 0b0101 → read returns 0xAA22CC44.
- Fixed burst: AR len 2, ap 0 at a word holding 7 → three beats of 7, rlast on the third.
- Arbitration: awvalid and arvalid raised together from reset → write granted first, read granted in the cycle the write burst ends + 1. Repeat with both pending again → read granted first.
- Reset mid-read: AR len 15, rst_n low for 1 cycle at beat 4 → rvalid=0 the next cycle, state IDLE; a subsequent AR completes normally.

Source files
------------

// File: rtl/fc_mem_slave.sv
// Memory responder for the FC datapath: round-robin AW/AR arbitration, byte-strobed
// write bursts and gap-free read bursts served from a single synchronous SRAM port.
module fc_mem_slave #(
    parameter int width = 32,
    parameter int depth = 1024,
    parameter int aw    = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [aw-1:0]        awaddr,
    input  logic [3:0]           awlen,
    input  logic [3:0]           awuser_id,
    input  logic                 awuser_ap,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [width-1:0]     wdata,
    input  logic [width/8-1:0]   wstrb,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [3:0]           wuser_id,
    output logic                 wuser_last,
    input  logic [aw-1:0]        araddr,
    input  logic [3:0]           arlen,
    input  logic [3:0]           aruser_id,
    input  logic                 aruser_ap,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [width-1:0]     rdata,
    output logic                 rvalid,
    output logic                 rlast,
    output logic [3:0]           rid
);

    localparam int nbytes = width / 8;
    localparam int lsb    = $clog2(nbytes);
    localparam int iw     = $clog2(depth);

    typedef logic [iw-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD} state_t;

    state_t            state_q, state_d;
    logic              pick_rd_q, pick_rd_d;
    idx_t              idx_q, idx_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ap_q, ap_d;
    logic [3:0]        wid_q, wid_d;
    logic [3:0]        rid_q, rid_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [width-1:0]  rdata_q;

    logic [width-1:0]  mem [depth];

    logic              idle;
    logic              aw_hs;
    logic              ar_hs;
    logic              wr_en;
    logic              rd_en;

    // Only the word-index slice of each address is meaningful.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{awaddr, araddr};

    always_comb begin
        idle    = (state_q == IDLE);
        awready = idle & awvalid & ~(arvalid & pick_rd_q);
        arready = idle & arvalid & ~(awvalid & ~pick_rd_q);
        aw_hs   = awvalid & awready;
        ar_hs   = arvalid & arready;
    end

    assign wready     = (state_q == WR);
    assign wuser_id   = wid_q;
    assign wuser_last = (state_q == WR) && (cnt_q == len_q);
    assign rvalid     = rvalid_q;
    assign rlast      = rlast_q;
    assign rid        = rid_q;
    assign rdata      = rdata_q;

    assign wr_en = rst_n && (state_q == WR) && wvalid;
    assign rd_en = (state_q == RD_ISSUE) || ((state_q == RD) && !rlast_q);

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        pick_rd_d = pick_rd_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        ap_d      = ap_q;
        wid_d     = wid_q;
        rid_d     = rid_q;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    state_d   = WR;
                    idx_d     = awaddr[lsb +: iw];
                    len_d     = awlen;
                    ap_d      = awuser_ap;
                    wid_d     = awuser_id;
                    cnt_d     = '0;
                    pick_rd_d = 1'b1;
                end else if (ar_hs) begin
                    state_d   = RD_ISSUE;
                    idx_d     = araddr[lsb +: iw];
                    len_d     = arlen;
                    ap_d      = aruser_ap;
                    rid_d     = aruser_id;
                    cnt_d     = '0;
                    pick_rd_d = 1'b0;
                end
            end
            WR: begin
                if (wvalid) begin
                    cnt_d = cnt_q + 4'd1;
                    if (ap_q) idx_d = idx_q + 1'b1;
                    if (cnt_q == len_q) state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                state_d  = RD;
                rvalid_d = 1'b1;
                rlast_d  = (len_q == '0);
                cnt_d    = cnt_q + 4'd1;
                if (ap_q) idx_d = idx_q + 1'b1;
            end
            RD: begin
                // The read for beat cnt_q is issued while the previous beat is on the bus.
                if (rlast_q) begin
                    state_d = IDLE;
                end else begin
                    rvalid_d = 1'b1;
                    rlast_d  = (cnt_q == len_q);
                    cnt_d    = cnt_q + 4'd1;
                    if (ap_q) idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pick_rd_q <= 1'b0;
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            ap_q      <= 1'b0;
            wid_q     <= '0;
            rid_q     <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pick_rd_q <= pick_rd_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ap_q      <= ap_d;
            wid_q     <= wid_d;
            rid_q     <= rid_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            if (rd_en) rdata_q <= mem[idx_q];
        end
    end

    // NOTE: the array has no reset so it maps onto plain SRAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < nbytes; b++) begin
                if (wstrb[b]) mem[idx_q][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_fc_mem_slave.sv
// Directed bench for fc_mem_slave: a per-cycle expectation schedule built from the
// transaction rules and a word-level memory model, checked on every falling edge.
module tb_fc_mem_slave;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 28;
    localparam int NCYC  = 2048;

    logic              clk;
    logic              rst_n;
    logic [AW-1:0]     awaddr, araddr;
    logic [3:0]        awlen, awuser_id, arlen, aruser_id;
    logic              awuser_ap, awvalid, aruser_ap, arvalid;
    logic              awready, arready;
    logic [WIDTH-1:0]  wdata, rdata;
    logic [3:0]        wstrb;
    logic              wvalid, wready, wuser_last;
    logic [3:0]        wuser_id, rid;
    logic              rvalid, rlast;

    fc_mem_slave #(.width(WIDTH), .depth(DEPTH), .aw(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awlen(awlen), .awuser_id(awuser_id), .awuser_ap(awuser_ap),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .wuser_id(wuser_id), .wuser_last(wuser_last),
        .araddr(araddr), .arlen(arlen), .aruser_id(aruser_id), .aruser_ap(aruser_ap),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rid(rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit        exp_awready [NCYC];
    bit        exp_arready [NCYC];
    bit        exp_wready  [NCYC];
    bit        exp_wlast   [NCYC];
    bit [3:0]  exp_wid     [NCYC];
    bit        exp_rvalid  [NCYC];
    bit        exp_rlast   [NCYC];
    bit [3:0]  exp_rid     [NCYC];
    bit [31:0] exp_rdata   [NCYC];

    logic [31:0] mem_m [DEPTH];
    bit          pick_m;
    logic [31:0] rd_log [$];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [27:0] a);
        return int'(a >> 2) % DEPTH;
    endfunction

    always @(negedge clk) begin
        if (cyc > 0 && cyc < NCYC) begin
            check("awready",    32'(awready),    32'(exp_awready[cyc]));
            check("arready",    32'(arready),    32'(exp_arready[cyc]));
            check("wready",     32'(wready),     32'(exp_wready[cyc]));
            check("wuser_last", 32'(wuser_last), 32'(exp_wlast[cyc]));
            check("rvalid",     32'(rvalid),     32'(exp_rvalid[cyc]));
            check("rlast",      32'(rlast),      32'(exp_rlast[cyc]));
            if (exp_wready[cyc]) check("wuser_id", 32'(wuser_id), 32'(exp_wid[cyc]));
            if (exp_rvalid[cyc]) begin
                check("rid",   32'(rid), 32'(exp_rid[cyc]));
                check("rdata", rdata,    exp_rdata[cyc]);
            end
            if (rvalid) rd_log.push_back(rdata);
        end
    end

    task automatic sched_read(input int t, input logic [27:0] addr, input logic [3:0] len,
                              input logic [3:0] id, input logic ap, input int last_beat);
        int base, c, ix;
        base = idx_of(addr);
        exp_arready[t] = 1'b1;
        pick_m = 1'b0;
        for (int k = 0; k <= last_beat; k++) begin
            c  = t + 2 + k;
            ix = ap ? (base + k) % DEPTH : base;
            exp_rvalid[c] = 1'b1;
            exp_rdata[c]  = mem_m[ix];
            exp_rlast[c]  = (k == int'(len));
            exp_rid[c]    = id;
        end
    endtask

    task automatic wbeat(input logic [3:0] id, input bit last, input logic [31:0] d,
                         input logic [3:0] s, input int ix, input bit valid);
        wvalid = valid;
        wdata  = d;
        wstrb  = s;
        exp_wready[cyc] = 1'b1;
        exp_wid[cyc]    = id;
        exp_wlast[cyc]  = last;
        if (valid) begin
            for (int b = 0; b < 4; b++) if (s[b]) mem_m[ix][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk); #1;
    endtask

    // Starts and ends 1 ns after a rising edge with the responder idle.
    task automatic wr_burst(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input logic ap, input int stall_before);
        int base;
        base = idx_of(addr);
        awaddr = addr; awlen = len; awuser_id = id; awuser_ap = ap; awvalid = 1'b1;
        exp_awready[cyc] = 1'b1;
        pick_m = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            if (k == stall_before) wbeat(id, k == int'(len), 32'h0, 4'h0, 0, 1'b0);
            wbeat(id, k == int'(len), wd[k], ws[k], ap ? (base + k) % DEPTH : base, 1'b1);
        end
        wvalid = 1'b0;
        wstrb  = 4'h0;
    endtask

    task automatic rd_burst(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input logic ap, input int abort_at);
        int t;
        t = cyc;
        araddr = addr; arlen = len; aruser_id = id; aruser_ap = ap; arvalid = 1'b1;
        sched_read(t, addr, len, id, ap, (abort_at >= 0) ? abort_at : int'(len));
        rd_log.delete();
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (abort_at < 0) begin
            repeat (int'(len) + 2) @(posedge clk);
            #1;
        end else begin
            repeat (abort_at + 1) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n  = 1'b1;
            pick_m = 1'b0;
            check("rdata_after_reset", rdata, 32'h0);
            check("beats_before_reset", 32'(rd_log.size()), 32'(abort_at + 1));
        end
    endtask

    task automatic expect_beats(input string name, input logic [31:0] v0, input logic [31:0] v1,
                                input logic [31:0] v2, input logic [31:0] v3, input int n);
        logic [31:0] lit [4];
        lit = '{v0, v1, v2, v3};
        check({name, "_count"}, 32'(rd_log.size()), 32'(n));
        for (int i = 0; i < n && i < rd_log.size(); i++) check(name, rd_log[i], lit[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awlen = '0; awuser_id = '0; awuser_ap = 1'b0; awvalid = 1'b0;
        araddr = '0; arlen = '0; aruser_id = '0; aruser_ap = 1'b0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        pick_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata",    rdata,          32'h0);
        check("reset_rid",      32'(rid),       32'h0);
        check("reset_wuser_id", 32'(wuser_id),  32'h0);
        rst_n = 1'b1;

        // Single write then read of the same word, read accepted right after the write ends.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        wr_burst(28'h10, 4'd0, 4'd3, 1'b1, -1);
        rd_burst(28'h10, 4'd0, 4'd5, 1'b1, -1);
        expect_beats("single_rd", 32'hDEADBEEF, 0, 0, 0, 1);

        // Incrementing burst wrapping from depth-2 through index 1.
        for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
        wr_burst(28'hFF8, 4'd3, 4'd1, 1'b1, -1);
        rd_burst(28'hFF8, 4'd3, 4'd2, 1'b1, -1);
        expect_beats("wrap_rd", 32'd1, 32'd2, 32'd3, 32'd4, 4);
        rd_burst(28'h0, 4'd1, 4'd8, 1'b1, -1);
        expect_beats("wrap_low_rd", 32'd3, 32'd4, 0, 0, 2);

        // Upper and low address bits are ignored: this aliases word 4.
        wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
        wr_burst(28'h8000013, 4'd0, 4'd6, 1'b1, -1);
        rd_burst(28'h10, 4'd0, 4'd7, 1'b1, -1);
        expect_beats("alias_rd", 32'h0BADF00D, 0, 0, 0, 1);

        // Byte strobes merge with existing contents.
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        wr_burst(28'h40, 4'd0, 4'd2, 1'b1, -1);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        wr_burst(28'h40, 4'd0, 4'd2, 1'b1, -1);
        rd_burst(28'h40, 4'd0, 4'd4, 1'b1, -1);
        expect_beats("strobe_rd", 32'hAA22CC44, 0, 0, 0, 1);

        // Fixed-address read burst.
        wd[0] = 32'd7; ws[0] = 4'hF;
        wr_burst(28'h80, 4'd0, 4'd1, 1'b1, -1);
        rd_burst(28'h80, 4'd2, 4'd11, 1'b0, -1);
        expect_beats("fixed_rd", 32'd7, 32'd7, 32'd7, 0, 3);

        // Fixed-address write with a stall, then incrementing write with a stall on the last beat.
        wd[0] = 32'h10; wd[1] = 32'h20; wd[2] = 32'h30; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        wr_burst(28'hC0, 4'd2, 4'd4, 1'b0, 1);
        rd_burst(28'hC0, 4'd0, 4'd4, 1'b1, -1);
        expect_beats("fixed_wr_rd", 32'h30, 0, 0, 0, 1);
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
        wr_burst(28'h100, 4'd2, 4'd12, 1'b1, 2);
        rd_burst(28'h100, 4'd2, 4'd13, 1'b1, -1);
        expect_beats("stall_wr_rd", 32'hA, 32'hB, 32'hC, 0, 3);

        // Arbitration from a fresh reset: both channels contend repeatedly.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pick_m = 1'b0;
        awaddr = 28'h300; awlen = 4'd1; awuser_id = 4'd9; awuser_ap = 1'b1; awvalid = 1'b1;
        araddr = 28'h10;  arlen = 4'd0; aruser_id = 4'd6; aruser_ap = 1'b1; arvalid = 1'b1;
        exp_awready[cyc] = !pick_m;
        exp_arready[cyc] = pick_m;
        pick_m = 1'b1;
        @(posedge clk); #1;
        awaddr = 28'h304; awlen = 4'd0; awuser_id = 4'd2;
        wbeat(4'd9, 1'b0, 32'h5000, 4'hF, idx_of(28'h300), 1'b1);
        wbeat(4'd9, 1'b1, 32'h5001, 4'hF, idx_of(28'h304), 1'b1);
        wvalid = 1'b0;
        check("arb_model_favours_read", 32'(pick_m), 32'd1);
        exp_awready[cyc] = !pick_m;
        sched_read(cyc, 28'h10, 4'd0, 4'd6, 1'b1, 0);
        rd_log.delete();
        @(posedge clk); #1;
        araddr = 28'h300; arlen = 4'd1; aruser_id = 4'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_beats("arb_rd_first", 32'h0BADF00D, 0, 0, 0, 1);
        rd_log.delete();
        exp_awready[cyc] = !pick_m;
        exp_arready[cyc] = pick_m;
        pick_m = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wbeat(4'd2, 1'b1, 32'h6000, 4'hF, idx_of(28'h304), 1'b1);
        wvalid = 1'b0;
        sched_read(cyc, 28'h300, 4'd1, 4'd1, 1'b1, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_beats("arb_rd_second", 32'h5000, 32'h6000, 0, 0, 2);

        // Reset in the middle of a 16-beat read, then a normal read.
        for (int k = 0; k < 16; k++) begin wd[k] = 32'(k * 32'h111 + 1); ws[k] = 4'hF; end
        wr_burst(28'h200, 4'd15, 4'd5, 1'b1, -1);
        rd_burst(28'h200, 4'd15, 4'd9, 1'b1, 4);
        rd_burst(28'h100, 4'd2, 4'd3, 1'b1, -1);
        expect_beats("after_reset_rd", 32'hA, 32'hB, 32'hC, 0, 3);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
